// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage. Owns the fetch PC, drives the
// instruction-memory address, captures the combinational read word into a
// small FIFO of {pc, instr} entries, and hands entries to decode over a
// valid/ready handshake. A redirect flushes the queue and reloads the PC.
module fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic [31:0]              imem_addr,
   input  logic [31:0]              imem_rd,
   input  logic                     redirect_valid,
   input  logic [31:0]              redirect_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_instr,
   output logic [31:0]              out_pc,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     misaligned
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fq_entry_t;

   fq_entry_t          mem [DEPTH];
   logic [PW-1:0]      rd_ptr, wr_ptr;
   logic [31:0]        fetch_pc;
   logic               pop, push_ok, push, pop_eff;

   // Outputs come straight from registers (head entry is a register-file read).
   assign imem_addr = fetch_pc;
   assign out_valid = (count != '0);
   assign out_pc    = mem[rd_ptr].pc;
   assign out_instr = mem[rd_ptr].instr;

   // Handshake qualifiers. A redirect suppresses both push and pop, so a pop
   // offered in the redirect cycle is simply dropped along with the flush.
   assign pop     = out_valid & out_ready;
   assign push_ok = (count < FULL_CNT) | pop;
   assign push    = push_ok & ~redirect_valid;
   assign pop_eff = pop & ~redirect_valid;

   // Queue storage; contents are don't-care after reset/flush, so no reset here.
   always_ff @(posedge clk) begin
      if (!rst && push)
         mem[wr_ptr] <= '{pc: fetch_pc, instr: imem_rd};
   end

   // Fetch PC, pointers, occupancy and the misaligned-redirect pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc   <= RESET_PC;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         misaligned <= 1'b0;
      end else if (redirect_valid) begin
         fetch_pc   <= {redirect_pc[31:2], 2'b00};
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         misaligned <= |redirect_pc[1:0];
      end else begin
         misaligned <= 1'b0;
         if (push) begin
            wr_ptr   <= wr_ptr + 1'b1;
            fetch_pc <= fetch_pc + 32'd4;
         end
         if (pop_eff)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop_eff})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a scoreboard of expected fetch PCs.
// The stimulus process loads the scoreboard with the PC stream the queue
// must deliver (from reset or from a redirect target); the monitor pops and
// compares on every accepted handshake.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_rd;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [2:0]  count;
   logic        misaligned;

   int checks = 0;
   int errors = 0;
   logic [31:0] sb[$];

   always #5 clk = ~clk;

   fetch_queue #(.RESET_PC(32'h0), .DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .imem_addr(imem_addr), .imem_rd(imem_rd),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc),
      .count(count), .misaligned(misaligned)
   );

   // Instruction memory model: a few fixed words, one all-zero word, and a
   // recognisable filler elsewhere.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0033_0313;
         32'h0000_0004: return 32'h0043_0893;
         32'h0000_0008: return 32'h0113_06B3;
         32'h0000_0010: return 32'h0000_0000;
         32'h0000_001C: return 32'h0006_A583;
         default:       return {16'hC0DE, a[15:0]};
      endcase
   endfunction

   assign imem_rd = mem_word(imem_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic sb_load(input logic [31:0] start);
      sb.delete();
      for (int i = 0; i < 48; i++) sb.push_back(start + 32'(i * 4));
   endtask

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: every accepted head entry must be the next expected PC/word.
   always @(negedge clk) begin
      if (!rst && !redirect_valid && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got pc 0x%08h expected no entry", out_pc);
         end else begin
            logic [31:0] epc;
            epc = sb.pop_front();
            check("mon_pc", out_pc, epc);
            check("mon_instr", out_instr, mem_word(epc));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
      sb_load(32'h0);
      step(2);
      // Reset state
      check("rst_addr", imem_addr, 32'h0);
      check("rst_valid", {31'b0, out_valid}, 32'h0);
      check("rst_count", {29'b0, count}, 32'h0);
      check("rst_mis", {31'b0, misaligned}, 32'h0);

      // Test 1: streaming with out_ready=1
      rst = 1'b0;
      step();
      check("t1_valid", {31'b0, out_valid}, 32'h1);
      check("t1_pc0", out_pc, 32'h0);
      check("t1_in0", out_instr, 32'h0033_0313);
      step();
      check("t1_pc1", out_pc, 32'h4);
      check("t1_in1", out_instr, 32'h0043_0893);
      step();
      check("t1_pc2", out_pc, 32'h8);
      check("t1_in2", out_instr, 32'h0113_06B3);
      check("t1_count", {29'b0, count}, 32'h1);

      // Test 2: stall fills the queue, then drain without gaps
      rst = 1'b1; sb_load(32'h0);
      step();
      rst = 1'b0; out_ready = 1'b0;
      step(6);
      check("t2_count", {29'b0, count}, 32'h4);
      check("t2_addr", imem_addr, 32'h10);
      check("t2_head", out_pc, 32'h0);
      // Test 3: full with continuous ready: push+pop every cycle
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         check("t3_count", {29'b0, count}, 32'h4);
         check("t3_addr", imem_addr, 32'h14 + 32'(i * 4));
      end

      // Test 4: redirect with count=3 and a pop offered
      rst = 1'b1; sb_load(32'h0);
      step();
      rst = 1'b0; out_ready = 1'b0;
      step(3);
      check("t4_pre_count", {29'b0, count}, 32'h3);
      out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h1C;
      sb_load(32'h1C);
      step();
      redirect_valid = 1'b0;
      check("t4_count", {29'b0, count}, 32'h0);
      check("t4_valid", {31'b0, out_valid}, 32'h0);
      check("t4_addr", imem_addr, 32'h1C);
      check("t4_mis", {31'b0, misaligned}, 32'h0);
      step();
      check("t4_valid2", {31'b0, out_valid}, 32'h1);
      check("t4_pc", out_pc, 32'h1C);
      check("t4_instr", out_instr, 32'h0006_A583);
      step(2);

      // Test 5a: misaligned redirect
      redirect_valid = 1'b1; redirect_pc = 32'h22;
      sb_load(32'h20);
      step();
      redirect_valid = 1'b0;
      check("t5_addr", imem_addr, 32'h20);
      check("t5_mis1", {31'b0, misaligned}, 32'h1);
      step();
      check("t5_mis0", {31'b0, misaligned}, 32'h0);
      check("t5_pc", out_pc, 32'h20);
      step(2);

      // Test 5b: back-to-back redirects, last wins, then PC wrap
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      step();
      redirect_pc = 32'hFFFF_FFFC;
      sb_load(32'hFFFF_FFFC);
      step();
      redirect_valid = 1'b0;
      check("t5_wrap0", imem_addr, 32'hFFFF_FFFC);
      step();
      check("t5_wrap1", imem_addr, 32'h0);
      check("t5_wpc", out_pc, 32'hFFFF_FFFC);
      step(3);

      // Test 6: reset beats a simultaneous redirect
      rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h42;
      sb_load(32'h0);
      step();
      rst = 1'b0; redirect_valid = 1'b0;
      check("t6_addr", imem_addr, 32'h0);
      check("t6_count", {29'b0, count}, 32'h0);
      check("t6_mis", {31'b0, misaligned}, 32'h0);
      check("t6_valid", {31'b0, out_valid}, 32'h0);
      step(5);
      check("t6_sb_left", 32'(sb.size()), 32'(48 - 4));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
